// File: rtl/ov5640_power_seq.sv
// OV5640 power-on sequencer: walks PWDN/RESETB through power-up timing,
// then releases the SCCB master and watches for table-download completion.
module ov5640_power_seq #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int T_PWDN_US      = 5000,
    parameter int T_RST_US       = 1000,
    parameter int T_INIT_US      = 20000,
    parameter int CFG_TIMEOUT_US = 500000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       restart,
    input  logic       sccb_cfg_finish,
    output logic       ov5640_pwdn,
    output logic       ov5640_rst_n,
    output logic       sccb_rst,
    output logic       ov5640_setup_done,
    output logic       cam_ready,
    output logic       cfg_timeout,
    output logic [2:0] seq_state
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [19:0] LIM_PWDN = 20'(T_PWDN_US - 1);
    localparam logic [19:0] LIM_RST  = 20'(T_RST_US - 1);
    localparam logic [19:0] LIM_INIT = 20'(T_INIT_US - 1);
    localparam logic [19:0] LIM_CFG  = 20'(CFG_TIMEOUT_US - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWRUP  = 3'd1,
        S_RSTREL = 3'd2,
        S_CONFIG = 3'd3,
        S_READY  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [PW-1:0]   presc;
    logic [19:0]     cnt;
    logic            tick;
    logic            timed;

    // {pwdn, rst_n, sccb_rst, setup_done, cam_ready, cfg_timeout}
    function automatic logic [5:0] outs_of(state_t s);
        case (s)
            S_OFF:    return 6'b101000;
            S_PWRUP:  return 6'b001000;
            S_RSTREL: return 6'b011000;
            S_CONFIG: return 6'b010100;
            S_READY:  return 6'b010110;
            S_FAULT:  return 6'b010001;
            default:  return 6'b101000;
        endcase
    endfunction

    assign tick  = (presc == PW'(DIV - 1));
    assign timed = (state == S_OFF) || (state == S_PWRUP) ||
                   (state == S_RSTREL) || (state == S_CONFIG);

    always_comb begin
        nxt = state;
        unique case (state)
            S_OFF:    if (tick && cnt == LIM_PWDN) nxt = S_PWRUP;
            S_PWRUP:  if (tick && cnt == LIM_RST)  nxt = S_RSTREL;
            S_RSTREL: if (tick && cnt == LIM_INIT) nxt = S_CONFIG;
            // a finish arriving on the timeout edge still counts as success
            S_CONFIG: begin
                if (sccb_cfg_finish)
                    nxt = S_READY;
                else if (tick && cnt == LIM_CFG)
                    nxt = S_FAULT;
            end
            S_READY:  nxt = S_READY;
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_OFF;
        endcase
        if (restart) nxt = S_OFF;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_OFF;
            presc <= '0;
            cnt   <= '0;
            {ov5640_pwdn, ov5640_rst_n, sccb_rst,
             ov5640_setup_done, cam_ready, cfg_timeout} <= 6'b101000;
        end else begin
            state <= nxt;
            {ov5640_pwdn, ov5640_rst_n, sccb_rst,
             ov5640_setup_done, cam_ready, cfg_timeout} <= outs_of(nxt);
            if (restart || nxt != state || !timed) begin
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= cnt + 20'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Bench for ov5640_power_seq: cycle-level state/time model plus
// directed literal checks of the power-up and config scenarios.
module tb_ov5640_power_seq;

    localparam int CLK_HZ = 4_000_000;
    localparam int DIV    = 4;
    localparam int TP     = 3;
    localparam int TR     = 2;
    localparam int TI     = 5;
    localparam int TC     = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       finish = 1'b0;
    logic       pwdn, cam_rst_n, sccb_rst, setup_done, cam_ready, cfg_timeout;
    logic [2:0] seq_state;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    ov5640_power_seq #(
        .CLK_FREQ_HZ(CLK_HZ),
        .T_PWDN_US(TP),
        .T_RST_US(TR),
        .T_INIT_US(TI),
        .CFG_TIMEOUT_US(TC)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .restart(restart),
        .sccb_cfg_finish(finish),
        .ov5640_pwdn(pwdn),
        .ov5640_rst_n(cam_rst_n),
        .sccb_rst(sccb_rst),
        .ov5640_setup_done(setup_done),
        .cam_ready(cam_ready),
        .cfg_timeout(cfg_timeout),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    // Model: phase number and cycles spent in it; timed phases last T*DIV cycles.
    int m_st = 0;
    int m_el = 0;

    function automatic int dur(int s);
        case (s)
            0: return TP * DIV;
            1: return TR * DIV;
            2: return TI * DIV;
            3: return TC * DIV;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] tbl(int s);
        case (s)
            0: return 6'b101000;
            1: return 6'b001000;
            2: return 6'b011000;
            3: return 6'b010100;
            4: return 6'b010110;
            5: return 6'b010001;
            default: return 6'b000000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0;
            m_el = 0;
        end else if (restart) begin
            m_st = 0;
            m_el = 0;
        end else if (m_st == 3 && finish) begin
            m_st = 4;
            m_el = 0;
        end else if (m_st <= 3 && m_el + 1 == dur(m_st)) begin
            m_st = (m_st == 3) ? 5 : m_st + 1;
            m_el = 0;
        end else if (m_st <= 3) begin
            m_el = m_el + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [8:0] act, exp_v;
            act = {seq_state, pwdn, cam_rst_n, sccb_rst,
                   setup_done, cam_ready, cfg_timeout};
            exp_v = {3'(m_st), tbl(m_st)};
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL model t=%0t got=%b want=%b", $time, act, exp_v);
            end
        end
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
        end
    endtask

    task automatic tick_n(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts with the block parked in S_OFF and counters at zero.
    task automatic seq_up(string tag);
        tick_n(11); chk({tag, "_pwdn11"}, 8'(pwdn), 8'd1);
        tick_n(1);  chk({tag, "_pwdn12"}, 8'(pwdn), 8'd0);
        tick_n(7);  chk({tag, "_rstn19"}, 8'(cam_rst_n), 8'd0);
        tick_n(1);  chk({tag, "_rstn20"}, 8'(cam_rst_n), 8'd1);
        tick_n(19); chk({tag, "_setup39"}, 8'(setup_done), 8'd0);
        tick_n(1);  chk({tag, "_setup40"}, 8'(setup_done), 8'd1);
        chk({tag, "_sccbrst40"}, 8'(sccb_rst), 8'd0);
        chk({tag, "_state40"}, 8'(seq_state), 8'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 8'(seq_state), 8'd0);
        chk("rst_outs", {2'b0, pwdn, cam_rst_n, sccb_rst,
                         setup_done, cam_ready, cfg_timeout}, 8'b00101000);
        rst_n = 1'b1;
        started = 1'b1;

        // nominal
        seq_up("nom");
        tick_n(6);
        finish = 1'b1;
        chk("nom_notready", 8'(cam_ready), 8'd0);
        tick_n(1);
        chk("nom_ready", 8'(cam_ready), 8'd1);
        chk("nom_state", 8'(seq_state), 8'd4);
        finish = 1'b0;
        tick_n(3);

        // restart from ready, held 5 cycles
        restart = 1'b1;
        tick_n(1);
        chk("rs_off", 8'(seq_state), 8'd0);
        chk("rs_pwdn", 8'(pwdn), 8'd1);
        chk("rs_ready", 8'(cam_ready), 8'd0);
        tick_n(4);
        restart = 1'b0;
        seq_up("rs");

        // timeout
        tick_n(39);
        chk("to_pre", 8'(cfg_timeout), 8'd0);
        tick_n(1);
        chk("to_flag", 8'(cfg_timeout), 8'd1);
        chk("to_setup", 8'(setup_done), 8'd0);
        chk("to_state", 8'(seq_state), 8'd5);
        tick_n(100);
        chk("to_hold", 8'(seq_state), 8'd5);

        // finish and timeout on the same edge
        restart = 1'b1;
        tick_n(1);
        restart = 1'b0;
        seq_up("tie");
        tick_n(39);
        finish = 1'b1;
        tick_n(1);
        chk("tie_state", 8'(seq_state), 8'd4);
        chk("tie_to", 8'(cfg_timeout), 8'd0);
        finish = 1'b0;

        // async reset in the middle of RESETB release
        restart = 1'b1;
        tick_n(1);
        restart = 1'b0;
        tick_n(25);
        chk("ar_pre", 8'(seq_state), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 8'(seq_state), 8'd0);
        chk("ar_outs", {2'b0, pwdn, cam_rst_n, sccb_rst,
                        setup_done, cam_ready, cfg_timeout}, 8'b00101000);
        rst_n = 1'b1;
        seq_up("ar");

        // stale finish held through power-up
        restart = 1'b1;
        finish = 1'b1;
        tick_n(1);
        restart = 1'b0;
        seq_up("st");
        tick_n(1);
        chk("st_ready", 8'(seq_state), 8'd4);
        finish = 1'b0;
        tick_n(2);

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
